pipelined_ripple_adder: RTL and testbench
=========================================

Name: pipelined_ripple_adder

Overview:
Parametrised multi-bit adder/subtractor built as a chain of chunk adders with a register stage after each chunk. It is the sequential, handshaked successor of the single-bit half/full-adder cells and gives a WIDTH-bit add/sub at full clock rate, one result per cycle. It sits between an operand producer and a result consumer, with valid/ready on both sides.

Parameters:
WIDTH, 8, operand and sum width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages; each stage adds CHUNK = WIDTH/STAGES bits.

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  operand beat present.
in_ready  out  1  block accepts the beat this cycle.
in_a  in  WIDTH  operand A, unsigned or two's complement.
in_b  in  WIDTH  operand B.
in_c  in  1  carry-in; used only when in_sub=0.
in_sub  in  1  1 = A-B, 0 = A+B+in_c.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts the result.
out_sum  out  WIDTH  result bits.
out_carry  out  1  final carry out; in subtract mode 1 = no borrow.
out_ovf  out  1  signed overflow.

Behaviour:
- Reset is synchronous and active-high (rst); one clock, clk. On rst=1 at a clock edge: all stage valid bits, out_valid, out_sum, out_carry and out_ovf go to 0, and all stage data goes to 0. in_ready is 1 in the cycle after reset.
- Reset mid-operation discards every in-flight beat. No partial result is emitted.
- Operand preparation at entry:
  - b_eff = in_sub ? ~in_b : in_b.
  - cin = in_sub ? 1 : in_c.
- Stage k (0..STAGES-1):
  - Adds chunk k of A and b_eff plus the carry from stage k-1 (stage 0 uses cin).
  - Registers the CHUNK sum bits, the carry, and the not-yet-consumed upper chunks of A and b_eff (input skew).
  - Lower result chunks are carried forward unchanged (output deskew), so out_sum is always aligned.
- Overflow at the final stage: out_ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]). A[MSB] and b_eff[MSB] travel with the beat.
- Global stall enable: adv = out_ready | ~out_valid.
  - When adv=1, all stages shift one position; a stage with valid=0 carries a bubble.
  - When adv=0, every stage register holds.
  - in_ready = adv, combinational; there is no in_valid→in_ready path.
- A beat is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall. Throughput is 1 beat per cycle when out_ready is held high.
- Simultaneous accept and consume in the same cycle is legal and keeps throughput.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Bubbles are not collapsed during a stall; the pipeline shifts as a unit.
- Wrap-around is modulo 2^WIDTH: 0xFF+0x01 gives sum 0x00, carry 1.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Elaboration check: WIDTH % STAGES != 0 or STAGES < 1 raises a fatal error.

Decomposition:
- Shared package adder_pkg holds:
  - Function chunk_width(WIDTH, STAGES).
  - Struct type for the per-stage payload: sum-so-far, remaining A/B, carry, sign bits, valid.
  - Default parameter constants.
- One natural sub-module: chunk_adder. It is a combinational CHUNK-bit adder (a, b, cin → sum, cout), instantiated STAGES times via generate. The pipelined_ripple_adder top owns all registers and the handshake.

Test Plan:
- WIDTH=8, STAGES=4, out_ready=1; drive A=0x3C, B=0x05, c=1, sub=0 → 4 cycles later out_sum=0x42, carry=0, ovf=0, out_valid high for exactly 1 cycle.
- Wrap and overflow: A=0x7F, B=0x01, add → sum=0x80, carry=0, ovf=1. Then A=0xFF, B=0x01 → sum=0x00, carry=1, ovf=0.
- Subtract: A=0x05, B=0x07, sub=1 → sum=0xFE, carry=0 (borrow), ovf=0. Then A=0x80, B=0x01, sub=1 → sum=0x7F, ovf=1.
- Back-to-back: 16 random beats on consecutive cycles with out_ready=1 → 16 results on consecutive cycles starting at cycle 4, all matching the reference model, in_ready constantly 1.
- Backpressure: fill the pipe, drop out_ready for 5 cycles → in_ready=0 and out_sum/out_valid stable throughout. Raising out_ready yields results in order with no loss or duplication.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight → the next cycle has out_valid=0 and out_sum=0, and none of the 3 results ever appear. A new beat afterwards returns after 4 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants, payload types and helpers for the pipelined ripple adder.
package adder_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_STAGES = 4;

  // Control part of a stage payload. Each stage holds a different number of
  // sum bits and pending operand bits, so those vectors sit beside this struct.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  // Bits added per stage; zero for a degenerate stage count.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

endpackage

// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result handshake bundle for the pipelined ripple adder.
interface pipelined_ripple_adder_if #(
  parameter int unsigned WIDTH = adder_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_c;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;

  // Producer/consumer side.
  modport master (
    output in_valid, in_a, in_b, in_c, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, in_a, in_b, in_c, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf
  );

endinterface

// File: rtl/chunk_adder.sv
// Combinational W-bit adder with carry in and carry out.
module chunk_adder #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Widen by one bit so the carry falls out of the top.
  assign {cout, sum} = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);

endmodule

// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit add/sub split into STAGES registered chunk adders with a
// global stall: the whole pipe advances together or holds together.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic                    clk,
  input  logic                    rst,
  pipelined_ripple_adder_if.slave bus
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
  localparam int          LAST  = int'(STAGES) - 1;

  // Reject configurations that cannot be split into equal chunks.
  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "pipelined_ripple_adder: STAGES must be at least 1");
  end else if ((WIDTH % STAGES) != 0) begin : g_bad_width
    $fatal(1, "pipelined_ripple_adder: WIDTH must be a multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  // Advance whenever the output slot is free or being drained.
  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  // Subtraction is A + ~B + 1; addition uses the caller's carry.
  assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign cin0  = bus.in_sub | bus.in_c;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    // Operand bits still pending at this stage's input, and sum bits after it.
    localparam int unsigned IW = WIDTH - CHUNK * unsigned'(k);
    localparam int unsigned LO = CHUNK * unsigned'(k + 1);

    logic [IW-1:0]    a_in;
    logic [IW-1:0]    b_in;
    stage_ctl_t       ctl_in;
    stage_ctl_t       ctl_q;
    logic [CHUNK-1:0] csum;
    logic             cout;
    logic [LO-1:0]    sum_d;
    logic [LO-1:0]    sum_q;

    // Stage source: the entry port for stage 0, the previous register otherwise.
    if (k == 0) begin : g_src
      assign a_in   = bus.in_a;
      assign b_in   = b_eff;
      assign ctl_in = '{valid: bus.in_valid, carry: cin0};
      assign sum_d  = csum;
    end else begin : g_src
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign ctl_in = g_stage[k-1].ctl_q;
      assign sum_d  = {csum, g_stage[k-1].sum_q};
    end

    chunk_adder #(
      .W (CHUNK)
    ) u_chunk (
      .a    (a_in[CHUNK-1:0]),
      .b    (b_in[CHUNK-1:0]),
      .cin  (ctl_in.carry),
      .sum  (csum),
      .cout (cout)
    );

    // Stage register; bubbles carry zero data so idle outputs read as zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (adv) begin
        ctl_q.valid <= ctl_in.valid;
        ctl_q.carry <= ctl_in.valid & cout;
        sum_q       <= ctl_in.valid ? sum_d : '0;
      end
    end

    if (k < LAST) begin : g_fwd
      logic [IW-CHUNK-1:0] a_q;
      logic [IW-CHUNK-1:0] b_q;

      // Skew register for the operand chunks later stages still need.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= ctl_in.valid ? a_in[IW-1:CHUNK] : '0;
          b_q <= ctl_in.valid ? b_in[IW-1:CHUNK] : '0;
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Signed overflow: same-sign operands giving a different-sign result.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ctl_in.valid
                 & (a_in[IW-1] == b_in[IW-1])
                 & (csum[CHUNK-1] != a_in[IW-1]);
        end
      end
    end
  end

  assign bus.out_valid = g_stage[LAST].ctl_q.valid;
  assign bus.out_carry = g_stage[LAST].ctl_q.carry;
  assign bus.out_sum   = g_stage[LAST].sum_q;
  assign bus.out_ovf   = g_stage[LAST].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder (8-bit, 4 stages, plus a 1-stage copy).
module tb_pipelined_ripple_adder;
  import adder_pkg::*;

  localparam int unsigned W    = 8;
  localparam int unsigned S    = 4;
  localparam int          UMAX = (1 << W) - 1;
  localparam int          SMAX = (1 << (W - 1)) - 1;
  localparam int          SMIN = -(1 << (W - 1));

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipelined_ripple_adder_if #(.WIDTH(W)) bus ();
  pipelined_ripple_adder_if #(.WIDTH(W)) bus1 ();

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Reference: plain integer arithmetic on unsigned and signed readings of the operands.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic sub);
    int   ua, ub, sa, sb, u, s;
    res_t r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u       = ua - ub;
      s       = sa - sb;
      r.carry = (ua >= ub);
    end else begin
      u       = ua + ub + int'(c);
      s       = sa + sb + int'(c);
      r.carry = (u > UMAX);
    end
    r.sum = W'(u);
    r.ovf = (s > SMAX) || (s < SMIN);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_c       = 1'b0;
    bus.in_sub     = 1'b0;
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_a      = '0;
    bus1.in_b      = '0;
    bus1.in_c      = 1'b0;
    bus1.in_sub    = 1'b0;
    bus1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_sum !== 8'h00) begin
      n_bad++; $display("FAIL reset_out_sum: got %0h expected 0", bus.out_sum);
    end
    n_cmp++;
    if (bus.out_carry !== 1'b0 || bus.out_ovf !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: got carry=%0b ovf=%0b expected 0/0", bus.out_carry, bus.out_ovf);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready);
    end
    n_cmp++;
    if (bus1.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_s1_out_valid: got %0b expected 0", bus1.out_valid);
    end
  endtask

  // One isolated beat: result after exactly S edges, valid for exactly one cycle.
  task automatic test_single_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input logic sub, input string tag);
    res_t e;
    e             = model(a, b, c, sub);
    bus.out_ready = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_c      = c;
    bus.in_sub    = sub;
    bus.in_valid  = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s_in_ready: got %0b expected 1", tag, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    for (int cyc = 1; cyc <= S + 2; cyc++) begin
      n_cmp++;
      if (bus.out_valid !== (cyc == S)) begin
        n_bad++; $display("FAIL %s_valid c%0d: got %0b expected %0b", tag, cyc, bus.out_valid, (cyc == S));
      end
      if (cyc == S) begin
        n_cmp++;
        if (bus.out_sum !== e.sum || bus.out_carry !== e.carry || bus.out_ovf !== e.ovf) begin
          n_bad++;
          $display("FAIL %s_result: got sum=%0h c=%0b v=%0b expected sum=%0h c=%0b v=%0b",
                   tag, bus.out_sum, bus.out_carry, bus.out_ovf, e.sum, e.carry, e.ovf);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t e;
    logic [W-1:0] a, b;
    logic c, sub;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 16 + S + 2; t++) begin
      n_cmp++;
      if (bus.out_valid !== ((t >= S) && (t < 16 + S))) begin
        n_bad++; $display("FAIL b2b_valid t%0d: got %0b expected %0b", t, bus.out_valid, ((t >= S) && (t < 16 + S)));
      end
      if ((t >= S) && (t < 16 + S) && (q.size() != 0)) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.out_sum !== e.sum || bus.out_carry !== e.carry || bus.out_ovf !== e.ovf) begin
          n_bad++;
          $display("FAIL b2b_result t%0d: got sum=%0h c=%0b v=%0b expected sum=%0h c=%0b v=%0b",
                   t, bus.out_sum, bus.out_carry, bus.out_ovf, e.sum, e.carry, e.ovf);
        end
      end
      if (t < 16) begin
        a   = W'($urandom);
        b   = W'($urandom);
        c   = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_c     = c;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        q.push_back(model(a, b, c, sub));
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
          n_bad++; $display("FAIL b2b_in_ready t%0d: got %0b expected 1", t, bus.in_ready);
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 8;
    logic [W-1:0] ba[N], bb[N];
    logic         bc[N], bs[N];
    res_t         q[$];
    res_t         e;
    int           acc  = 0;
    int           cons = 0;
    logic [W-1:0] held_sum;
    logic         held_c, held_v;
    for (int i = 0; i < N; i++) begin
      ba[i] = W'($urandom);
      bb[i] = W'($urandom);
      bc[i] = 1'($urandom_range(0, 1));
      bs[i] = 1'($urandom_range(0, 1));
    end
    held_sum = '0;
    held_c   = 1'b0;
    held_v   = 1'b0;
    for (int t = 0; t < 40; t++) begin
      bus.out_ready = !((t >= 5) && (t < 10));
      if (acc < N) begin
        bus.in_a     = ba[acc];
        bus.in_b     = bb[acc];
        bus.in_c     = bc[acc];
        bus.in_sub   = bs[acc];
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if ((t >= 5) && (t < 10)) begin
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
          n_bad++; $display("FAIL bp_stall t%0d: got in_ready=%0b out_valid=%0b expected 0/1", t, bus.in_ready, bus.out_valid);
        end
        if (t == 5) begin
          held_sum = bus.out_sum;
          held_c   = bus.out_carry;
          held_v   = bus.out_ovf;
        end else begin
          n_cmp++;
          if (bus.out_sum !== held_sum || bus.out_carry !== held_c || bus.out_ovf !== held_v) begin
            n_bad++;
            $display("FAIL bp_hold t%0d: got sum=%0h c=%0b v=%0b expected sum=%0h c=%0b v=%0b",
                     t, bus.out_sum, bus.out_carry, bus.out_ovf, held_sum, held_c, held_v);
          end
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL bp_extra t%0d: got result sum=%0h expected none", t, bus.out_sum);
        end else begin
          e = q.pop_front();
          cons++;
          if (bus.out_sum !== e.sum || bus.out_carry !== e.carry || bus.out_ovf !== e.ovf) begin
            n_bad++;
            $display("FAIL bp_result t%0d: got sum=%0h c=%0b v=%0b expected sum=%0h c=%0b v=%0b",
                     t, bus.out_sum, bus.out_carry, bus.out_ovf, e.sum, e.carry, e.ovf);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(ba[acc], bb[acc], bc[acc], bs[acc]));
        acc++;
      end
      tick();
      if ((acc == N) && (q.size() == 0)) break;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_cmp++;
    if (cons !== N) begin
      n_bad++; $display("FAIL bp_count: got %0d results expected %0d", cons, N);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_drained: got out_valid=%0b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] a, b;
    res_t e;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      bus.in_a     = W'($urandom);
      bus.in_b     = W'($urandom);
      bus.in_c     = 1'($urandom_range(0, 1));
      bus.in_sub   = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 8'h00) begin
      n_bad++; $display("FAIL rstmid_after: got valid=%0b sum=%0h expected 0/0", bus.out_valid, bus.out_sum);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_in_ready: got %0b expected 1", bus.in_ready);
    end
    for (int t = 0; t < S + 3; t++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_ghost t%0d: got out_valid=%0b sum=%0h expected 0", t, bus.out_valid, bus.out_sum);
      end
    end
    a = W'($urandom);
    b = W'($urandom);
    e = model(a, b, 1'b0, 1'b1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_c     = 1'b0;
    bus.in_sub   = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int cyc = 1; cyc <= S + 1; cyc++) begin
      n_cmp++;
      if (bus.out_valid !== (cyc == S)) begin
        n_bad++; $display("FAIL rstmid_new_valid c%0d: got %0b expected %0b", cyc, bus.out_valid, (cyc == S));
      end
      if (cyc == S) begin
        n_cmp++;
        if (bus.out_sum !== e.sum || bus.out_carry !== e.carry || bus.out_ovf !== e.ovf) begin
          n_bad++;
          $display("FAIL rstmid_new_result: got sum=%0h c=%0b v=%0b expected sum=%0h c=%0b v=%0b",
                   bus.out_sum, bus.out_carry, bus.out_ovf, e.sum, e.carry, e.ovf);
        end
      end
      tick();
    end
  endtask

  // Single-stage instance: a plain registered adder, latency one.
  task automatic test_single_stage();
    res_t q[$];
    res_t e;
    logic [W-1:0] a, b;
    logic c, sub;
    bus1.out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      n_cmp++;
      if (bus1.out_valid !== ((t >= 1) && (t <= 8))) begin
        n_bad++; $display("FAIL s1_valid t%0d: got %0b expected %0b", t, bus1.out_valid, ((t >= 1) && (t <= 8)));
      end
      if ((t >= 1) && (t <= 8) && (q.size() != 0)) begin
        e = q.pop_front();
        n_cmp++;
        if (bus1.out_sum !== e.sum || bus1.out_carry !== e.carry || bus1.out_ovf !== e.ovf) begin
          n_bad++;
          $display("FAIL s1_result t%0d: got sum=%0h c=%0b v=%0b expected sum=%0h c=%0b v=%0b",
                   t, bus1.out_sum, bus1.out_carry, bus1.out_ovf, e.sum, e.carry, e.ovf);
        end
      end
      if (t < 8) begin
        a   = W'($urandom);
        b   = W'($urandom);
        c   = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        bus1.in_a     = a;
        bus1.in_b     = b;
        bus1.in_c     = c;
        bus1.in_sub   = sub;
        bus1.in_valid = 1'b1;
        q.push_back(model(a, b, c, sub));
      end else begin
        bus1.in_valid = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_beat(8'h3C, 8'h05, 1'b1, 1'b0, "add_basic");
    test_single_beat(8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf");
    test_single_beat(8'hFF, 8'h01, 1'b0, 1'b0, "add_wrap");
    test_single_beat(8'h05, 8'h07, 1'b0, 1'b1, "sub_borrow");
    test_single_beat(8'h80, 8'h01, 1'b1, 1'b1, "sub_ovf");
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_single_stage();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
